// File: rtl/fft_bitrev_reorder_pkg.sv
// Package fft_reorder_pkg: shared helpers for the FFT bit-reverse reorder buffer.
//   log2c()  - ceiling log2, used to size counters and RAM addresses
//   bitrev() - reverse the low nn bits of a value (nn <= 16)
//   rstate_e - read-side FSM state encoding
package fft_reorder_pkg;

    typedef enum logic {
        RSTATE_IDLE = 1'b0,
        RSTATE_READ = 1'b1
    } rstate_e;

    localparam int C_BITREV_MAX = 16;

    function automatic int log2c(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bit 0 of value ends up at bit nn-1 of the result; bits above nn-1 are zero.
    function automatic logic [C_BITREV_MAX-1:0] bitrev(input logic [C_BITREV_MAX-1:0] value,
                                                       input int nn);
        logic [C_BITREV_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < C_BITREV_MAX; i++) begin
            if (i < nn) begin
                r = {r[C_BITREV_MAX-2:0], value[i]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if: one direction of the FFT sample stream.
//   en - sample valid
//   re - real component, WIDTH bits
//   im - imaginary component, WIDTH bits
// master drives the stream, slave receives it.
interface fft_bitrev_reorder_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;

    modport master (output en, re, im);
    modport slave  (input  en, re, im);
endinterface

// File: rtl/fft_bitrev_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM backing the two reorder banks.
//   i_clk             - clock
//   i_we/i_waddr/i_wdata - write port
//   i_re/i_raddr      - read enable and address
//   o_rdata           - read data, registered (valid the cycle after i_re)
// The array has no reset; the top never reads a location before writing it.
module fft_reorder_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong reorder buffer behind the R22SDF FFT core.
// Frames arrive in bit-reversed order and leave in natural order, one sample
// per clock, back-to-back frames supported.
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-low
//   bypass - frame-boundary bypass request (only when REORDER_BYPASS_EN is defined)
//   s_di   - input stream (en/re/im), bit-reversed frame order
//   m_do   - output stream (en/re/im), natural order, registered
// Optional feature macro: REORDER_BYPASS_EN (adds bypass port and a 1-cycle
// pass-through path that keeps bit-reversed order).
//
// Read FSM
//   state       | meaning
//   RSTATE_IDLE | no frame being read out
//   RSTATE_READ | issuing read addresses {rbank, rcnt}, one per cycle
module fft_bitrev_reorder
    import fft_reorder_pkg::*;
#(
    parameter int N     = 128,
    parameter int WIDTH = 16
) (
    input  logic clock,
    input  logic reset,
`ifdef REORDER_BYPASS_EN
    input  logic bypass,
`endif
    fft_bitrev_reorder_if.slave  s_di,
    fft_bitrev_reorder_if.master m_do
);

    localparam int              NN     = log2c(N);
    localparam logic [NN-1:0]   C_LAST = NN'(N - 1);

    logic [NN-1:0]      r_wcnt;
    logic               r_wbank;
    logic [NN-1:0]      r_rcnt;
    logic               r_rbank;
    rstate_e            r_state;
    logic               r_rd_vld;

    logic               r_do_en;
    logic [WIDTH-1:0]   r_do_re;
    logic [WIDTH-1:0]   r_do_im;

    logic               w_byp;
    logic               w_we;
    logic               w_frame_done;
    logic               w_rd_active;
    logic [NN-1:0]      w_wcnt_rev;
    logic [NN:0]        w_waddr;
    logic [NN:0]        w_raddr;
    logic [2*WIDTH-1:0] w_rdata;

`ifdef REORDER_BYPASS_EN
    logic r_byp;
    logic w_byp_open;

    // Bypass may only change at a frame boundary with no read in flight;
    // the sampled value is used immediately for the first sample of the frame.
    assign w_byp_open = (r_wcnt == '0) && (r_state == RSTATE_IDLE);
    assign w_byp      = w_byp_open ? bypass : r_byp;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_byp <= 1'b0;
        end else if (w_byp_open) begin
            r_byp <= bypass;
        end
    end
`else
    assign w_byp = 1'b0;
`endif

    assign w_we         = s_di.en && !w_byp;
    assign w_frame_done = w_we && (r_wcnt == C_LAST);
    assign w_rd_active  = (r_state == RSTATE_READ);
    assign w_wcnt_rev   = NN'(bitrev(16'(r_wcnt), NN));
    assign w_waddr      = {r_wbank, w_wcnt_rev};
    assign w_raddr      = {r_rbank, r_rcnt};

    // Write side. The frame counter also runs in bypass so that the next
    // frame boundary is still known; the bank only flips on reordered frames.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else begin
            if (s_di.en) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_frame_done) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= RSTATE_IDLE;
            r_rbank  <= 1'b0;
            r_rcnt   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            // RAM output is valid one cycle after the address is issued.
            r_rd_vld <= w_rd_active;
            case (r_state)
                RSTATE_IDLE: begin
                    if (w_frame_done) begin
                        r_state <= RSTATE_READ;
                        r_rbank <= r_wbank;
                        r_rcnt  <= '0;
                    end
                end
                RSTATE_READ: begin
                    r_rcnt <= r_rcnt + 1'b1;
                    if (r_rcnt == C_LAST) begin
                        if (w_frame_done) begin
                            // Next frame completes exactly as this one drains:
                            // chain straight into it with no idle cycle.
                            r_rbank <= r_wbank;
                            r_rcnt  <= '0;
                        end else begin
                            r_state <= RSTATE_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= RSTATE_IDLE;
                end
            endcase
        end
    end

    fft_reorder_ram #(
        .AW (NN + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata ({s_di.re, s_di.im}),
        .i_re    (w_rd_active),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Data registers only load on a valid sample, so they hold between frames.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_do_en <= 1'b0;
            r_do_re <= '0;
            r_do_im <= '0;
        end else if (r_rd_vld) begin
            r_do_en <= 1'b1;
            r_do_re <= w_rdata[2*WIDTH-1:WIDTH];
            r_do_im <= w_rdata[WIDTH-1:0];
        end else if (w_byp && s_di.en) begin
            r_do_en <= 1'b1;
            r_do_re <= s_di.re;
            r_do_im <= s_di.im;
        end else begin
            r_do_en <= 1'b0;
        end
    end

    assign m_do.en = r_do_en;
    assign m_do.re = r_do_re;
    assign m_do.im = r_do_im;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder. Three instances: N=128/WIDTH=16 (directed
// and random), N=8/WIDTH=12 and N=1024/WIDTH=12 (parameter sweep). A reference
// model collects whole input frames and predicts out[m] = in[bitrev(m)] at
// cycle (last input edge + 2 + m); bypass frames predict in[k] one cycle later.
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;

    logic clk;
    logic rst_n;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef REORDER_BYPASS_EN
    logic bypass;
`endif

    fft_bitrev_reorder_if #(.WIDTH(16)) in0 ();
    fft_bitrev_reorder_if #(.WIDTH(16)) out0 ();
    fft_bitrev_reorder_if #(.WIDTH(12)) in1 ();
    fft_bitrev_reorder_if #(.WIDTH(12)) out1 ();
    fft_bitrev_reorder_if #(.WIDTH(12)) in2 ();
    fft_bitrev_reorder_if #(.WIDTH(12)) out2 ();

    fft_bitrev_reorder #(.N(128), .WIDTH(16)) dut (
        .clock (clk),
        .reset (rst_n),
`ifdef REORDER_BYPASS_EN
        .bypass(bypass),
`endif
        .s_di  (in0),
        .m_do  (out0)
    );

    fft_bitrev_reorder #(.N(8), .WIDTH(12)) dut_n8 (
        .clock (clk),
        .reset (rst_n),
`ifdef REORDER_BYPASS_EN
        .bypass(1'b0),
`endif
        .s_di  (in1),
        .m_do  (out1)
    );

    fft_bitrev_reorder #(.N(1024), .WIDTH(12)) dut_n1024 (
        .clock (clk),
        .reset (rst_n),
`ifdef REORDER_BYPASS_EN
        .bypass(1'b0),
`endif
        .s_di  (in2),
        .m_do  (out2)
    );

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        int          cyc;
    } exp_t;

    typedef struct {
        int inst;
        int base;
        int nfr;
        int gap_at;
        int gap_len;
        int stop_at;
        bit rnd;
        int exp_out;
    } scen_t;

    int          NS  [3] = '{128, 8, 1024};
    int          NNS [3] = '{7, 3, 10};
    exp_t        expq [3][$];
    logic [31:0] fbuf [3][1024];
    int          cnt  [3];
    int          n_out[3];
    logic [15:0] cap_re[128];
    logic [15:0] cap_im[128];
    int          cap_n;
    bit          rec_on;
    bit          byp_lat;

    int n_vec;
    int n_err;

    function automatic int tb_bitrev(input int v, input int nbits);
        int r;
        int x;
        r = 0;
        x = v;
        for (int i = 0; i < nbits; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic chk(input bit ok, input string name, input int inst,
                       input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", name, inst, cyc, got, want);
        end
    endtask

    task automatic put(input int inst, input logic en, input logic [15:0] re, input logic [15:0] im);
        case (inst)
            0: begin in0.en = en; in0.re = re;       in0.im = im;       end
            1: begin in1.en = en; in1.re = re[11:0]; in1.im = im[11:0]; end
            default: begin in2.en = en; in2.re = re[11:0]; in2.im = im[11:0]; end
        endcase
    endtask

    // Drives one frame from posedge+1; returns at posedge+1 after the last sample.
    task automatic send(input int inst, input int base, input int gap_at, input int gap_len,
                        input int stop_at, input bit rnd);
        logic [15:0] re;
        logic [15:0] im;
        int          g;
        for (int n = 0; n < NS[inst]; n++) begin
            if (n == stop_at) break;
            g = 0;
            if (n == gap_at) g = gap_len;
            else if (rnd && $urandom_range(7) == 0) g = $urandom_range(1, 3);
            if (g > 0) begin
                put(inst, 1'b0, 16'h0, 16'h0);
                repeat (g) @(posedge clk);
                #1;
            end
            re = rnd ? 16'($urandom) : 16'(base + n);
            im = rnd ? 16'($urandom) : ~16'(base + n);
            if (inst != 0) begin
                re = {4'h0, re[11:0]};
                im = {4'h0, im[11:0]};
            end
            put(inst, 1'b1, re, im);
            @(posedge clk);
            #1;
        end
        put(inst, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic wait_idle(input int inst);
        int k;
        k = 0;
        while (expq[inst].size() != 0 && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk(expq[inst].size() == 0, "drain_timeout", inst, 64'(expq[inst].size()), 64'd0);
    endtask

    task automatic monitor();
        logic        oen[3];
        logic [15:0] ore[3];
        logic [15:0] oim[3];
        logic        ien[3];
        logic [15:0] ire[3];
        logic [15:0] iim[3];
        exp_t        e;
        int          nn;
        forever begin
            @(negedge clk);
            oen[0] = out0.en; ore[0] = out0.re;       oim[0] = out0.im;
            oen[1] = out1.en; ore[1] = 16'(out1.re);  oim[1] = 16'(out1.im);
            oen[2] = out2.en; ore[2] = 16'(out2.re);  oim[2] = 16'(out2.im);
            ien[0] = in0.en;  ire[0] = in0.re;        iim[0] = in0.im;
            ien[1] = in1.en;  ire[1] = 16'(in1.re);   iim[1] = 16'(in1.im);
            ien[2] = in2.en;  ire[2] = 16'(in2.re);   iim[2] = 16'(in2.im);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    chk(!oen[i] && ore[i] == 16'h0 && oim[i] == 16'h0, "reset_out", i,
                        {31'h0, oen[i], ore[i], oim[i]}, 64'h0);
                    cnt[i] = 0;
                    expq[i].delete();
                    if (i == 0) byp_lat = 1'b0;
                end else begin
                    if (expq[i].size() != 0 && expq[i][0].cyc == cyc) begin
                        e = expq[i].pop_front();
                        chk(oen[i] && ore[i] == e.re && oim[i] == e.im, "sample", i,
                            {31'h0, oen[i], ore[i], oim[i]}, {31'h0, 1'b1, e.re, e.im});
                        n_out[i]++;
                        if (i == 0 && rec_on && cap_n < 128) begin
                            cap_re[cap_n] = ore[0];
                            cap_im[cap_n] = oim[0];
                            cap_n++;
                        end
                    end else begin
                        chk(!oen[i], "idle_en", i, 64'(oen[i]), 64'd0);
                    end
`ifdef REORDER_BYPASS_EN
                    if (i == 0 && cnt[0] == 0 && expq[0].size() == 0) byp_lat = bypass;
`endif
                    if (ien[i]) begin
                        nn = NS[i];
                        if (i == 0 && byp_lat) begin
                            e.re = ire[i]; e.im = iim[i]; e.cyc = cyc + 1;
                            expq[i].push_back(e);
                        end else begin
                            fbuf[i][cnt[i]] = {ire[i], iim[i]};
                        end
                        cnt[i]++;
                        if (cnt[i] == nn) begin
                            cnt[i] = 0;
                            if (!(i == 0 && byp_lat)) begin
                                for (int m = 0; m < nn; m++) begin
                                    e.re  = fbuf[i][tb_bitrev(m, NNS[i])][31:16];
                                    e.im  = fbuf[i][tb_bitrev(m, NNS[i])][15:0];
                                    e.cyc = cyc + 3 + m;
                                    expq[i].push_back(e);
                                end
                            end
                        end
                    end
                end
            end
        end
    endtask

    scen_t scen[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1);
    end

    initial begin
        scen[0] = '{inst:0, base:'h000, nfr:1, gap_at:-1, gap_len:0, stop_at:-1, rnd:0, exp_out:128};
        scen[1] = '{inst:0, base:'h000, nfr:3, gap_at:-1, gap_len:0, stop_at:-1, rnd:0, exp_out:384};
        scen[2] = '{inst:0, base:'h000, nfr:1, gap_at:41, gap_len:5, stop_at:-1, rnd:0, exp_out:128};
        scen[3] = '{inst:0, base:'h300, nfr:1, gap_at:-1, gap_len:0, stop_at:60, rnd:0, exp_out:128};
        scen[4] = '{inst:0, base:'h000, nfr:3, gap_at:-1, gap_len:0, stop_at:-1, rnd:1, exp_out:384};
        scen[5] = '{inst:1, base:'h000, nfr:4, gap_at:-1, gap_len:0, stop_at:-1, rnd:1, exp_out:32};
        scen[6] = '{inst:1, base:'h010, nfr:2, gap_at:-1, gap_len:0, stop_at:-1, rnd:0, exp_out:16};
        scen[7] = '{inst:2, base:'h000, nfr:2, gap_at:-1, gap_len:0, stop_at:-1, rnd:1, exp_out:2048};

        n_vec = 0; n_err = 0; cap_n = 0; rec_on = 0; byp_lat = 0;
        for (int i = 0; i < 3; i++) begin cnt[i] = 0; n_out[i] = 0; end
        rst_n = 1'b0;
`ifdef REORDER_BYPASS_EN
        bypass = 1'b0;
`endif
        put(0, 1'b0, 16'h0, 16'h0);
        put(1, 1'b0, 16'h0, 16'h0);
        put(2, 1'b0, 16'h0, 16'h0);

        fork
            monitor();
            begin
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;

                for (int s = 0; s < 8; s++) begin
                    n_out[scen[s].inst] = 0;
                    if (scen[s].stop_at >= 0) begin
                        // Partial frame, then reset: it must never appear at the output.
                        send(scen[s].inst, scen[s].base, -1, 0, scen[s].stop_at, 1'b0);
                        rst_n = 1'b0;
                        repeat (4) @(posedge clk);
                        #1;
                        rst_n = 1'b1;
                        @(posedge clk);
                        #1;
                    end
                    if (s == 0) begin rec_on = 1; cap_n = 0; end
                    for (int f = 0; f < scen[s].nfr; f++) begin
                        send(scen[s].inst, scen[s].base + (f + (scen[s].stop_at >= 0 ? 1 : 0)) * 'h100,
                             scen[s].gap_at, scen[s].gap_len, -1, scen[s].rnd);
                    end
                    wait_idle(scen[s].inst);
                    rec_on = 0;
                    chk(n_out[scen[s].inst] == scen[s].exp_out, "frame_len", scen[s].inst,
                        64'(n_out[scen[s].inst]), 64'(scen[s].exp_out));
                    if (s == 0) begin
                        for (int m = 0; m < 128; m++) begin
                            chk(cap_re[m] == 16'(tb_bitrev(m, 7)) && cap_im[m] == ~16'(tb_bitrev(m, 7)),
                                "natural_order", 0, {32'h0, cap_re[m], cap_im[m]},
                                {32'h0, 16'(tb_bitrev(m, 7)), ~16'(tb_bitrev(m, 7))});
                        end
                    end
                end

`ifdef REORDER_BYPASS_EN
                // Bypass frame with a mid-frame toggle that must be ignored,
                // followed by a normal reordered frame.
                n_out[0] = 0;
                bypass = 1'b1;
                for (int n = 0; n < 128; n++) begin
                    if (n == 50) bypass = 1'b0;
                    put(0, 1'b1, 16'('h500 + n), ~16'('h500 + n));
                    @(posedge clk);
                    #1;
                end
                send(0, 'h600, -1, 0, -1, 1'b0);
                wait_idle(0);
                chk(n_out[0] == 256, "bypass_len", 0, 64'(n_out[0]), 64'd256);
`endif
            end
        join_any

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
